// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   F3_*         RV32I funct3 encodings for access size and sign
//   lsu_state_t  FSM state encoding
//   f3_legal     tells whether a funct3 value names a real load or store
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      FAULT
   } lsu_state_t;

   // Stores have no unsigned variants, so BU/HU are legal only for loads.
   function automatic logic f3_legal(input logic isStore, input logic [2:0] f3);
      logic legal;
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!isStore) begin
         legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return legal;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles the execute-stage request channel and the DataMemory port.
// Signals:
//   REQ, WEN, FUNCT3, ADDR, WDATA   request from execute
//   RDATA, DONE, ERR, BUSY          completion status back to execute
//   MEM_A, MEM_WD, MEM_WE           word-indexed access to memory
//   MEM_RD                          memory read data, one cycle after MEM_A
// Modports:
//   slave   the load/store unit itself
//   master  its environment (execute stage plus memory)
interface load_store_unit_if #(
   parameter int A_WIDTH = 32,
   parameter int D_WIDTH = 32
);

   logic               REQ;
   logic               WEN;
   logic [2:0]         FUNCT3;
   logic [A_WIDTH-1:0] ADDR;
   logic [D_WIDTH-1:0] WDATA;
   logic [D_WIDTH-1:0] RDATA;
   logic               DONE;
   logic               ERR;
   logic               BUSY;
   logic [A_WIDTH-1:0] MEM_A;
   logic [D_WIDTH-1:0] MEM_WD;
   logic               MEM_WE;
   logic [D_WIDTH-1:0] MEM_RD;

   modport slave (
      input  REQ, WEN, FUNCT3, ADDR, WDATA, MEM_RD,
      output RDATA, DONE, ERR, BUSY, MEM_A, MEM_WD, MEM_WE
   );

   modport master (
      output REQ, WEN, FUNCT3, ADDR, WDATA, MEM_RD,
      input  RDATA, DONE, ERR, BUSY, MEM_A, MEM_WD, MEM_WE
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   is_store_i     1 = store, 0 = load
//   funct3_i       access size / sign
//   addr_lo_i      byte offset within the word
//   mem_word_i     word read from memory
//   store_data_i   right-aligned store data
//   load_val_o     addressed byte/half/word, sign- or zero-extended
//   merged_o       mem_word_i with the addressed byte/half replaced
//   fault_o        request is misaligned or has an illegal funct3
module lsu_align
   import lsu_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic               is_store_i,
   input  logic [2:0]         funct3_i,
   input  logic [1:0]         addr_lo_i,
   input  logic [D_WIDTH-1:0] mem_word_i,
   input  logic [D_WIDTH-1:0] store_data_i,
   output logic [D_WIDTH-1:0] load_val_o,
   output logic [D_WIDTH-1:0] merged_o,
   output logic               fault_o
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;
   logic        misaligned;

   // Pick the addressed lanes out of the memory word; the half lane only
   // looks at addr[1] because an odd halfword address is a fault anyway.
   always_comb begin
      byteLane = mem_word_i[{addr_lo_i, 3'b000} +: 8];
      halfLane = mem_word_i[{addr_lo_i[1], 4'b0000} +: 16];
   end

   // Extend the selected lane to a full register value.
   always_comb begin
      load_val_o = mem_word_i;
      case (funct3_i)
         F3_B:    load_val_o = {{24{byteLane[7]}}, byteLane};
         F3_BU:   load_val_o = {24'h000000, byteLane};
         F3_H:    load_val_o = {{16{halfLane[15]}}, halfLane};
         F3_HU:   load_val_o = {16'h0000, halfLane};
         default: load_val_o = mem_word_i;
      endcase
   end

   // Overwrite only the addressed lane; every other byte keeps its old value.
   always_comb begin
      merged_o = mem_word_i;
      case (funct3_i)
         F3_B:    merged_o[{addr_lo_i, 3'b000} +: 8] = store_data_i[7:0];
         F3_H:    merged_o[{addr_lo_i[1], 4'b0000} +: 16] = store_data_i[15:0];
         default: merged_o = store_data_i;
      endcase
   end

   // funct3[1:0]==01 covers both H and HU.
   always_comb begin
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                   ((funct3_i == F3_W) && (addr_lo_i != 2'b00));
      fault_o    = !f3_legal(is_store_i, funct3_i) || misaligned;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a single-port synchronous DataMemory.
// Turns byte-addressed RV32I loads/stores into word accesses; sub-word
// stores are read-modify-write, bad requests finish with ERR and no write.
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   bus   load_store_unit_if.slave: request, status and memory signals
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   load_store_unit_if.slave       bus
);

   lsu_state_t         state_q, state_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic               wen_q, wen_d;
   logic [2:0]         f3_q, f3_d;
   logic [D_WIDTH-1:0] wd_q, wd_d;
   logic [D_WIDTH-1:0] wdata_m_q, wdata_m_d;
   logic [D_WIDTH-1:0] rdata_q, rdata_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               alignStore;
   logic [2:0]         alignF3;
   logic [1:0]         alignAddr;
   logic [D_WIDTH-1:0] loadVal;
   logic [D_WIDTH-1:0] mergedWord;
   logic               fault;

   // In IDLE the aligner judges the incoming request; afterwards it works on
   // the latched copy so that extract and merge see stable inputs.
   always_comb begin
      if (state_q == IDLE) begin
         alignStore = bus.WEN;
         alignF3    = bus.FUNCT3;
         alignAddr  = bus.ADDR[1:0];
      end else begin
         alignStore = wen_q;
         alignF3    = f3_q;
         alignAddr  = addr_q[1:0];
      end
   end

   lsu_align #(
      .D_WIDTH (D_WIDTH)
   ) u_align (
      .is_store_i   (alignStore),
      .funct3_i     (alignF3),
      .addr_lo_i    (alignAddr),
      .mem_word_i   (bus.MEM_RD),
      .store_data_i (wd_q),
      .load_val_o   (loadVal),
      .merged_o     (mergedWord),
      .fault_o      (fault)
   );

   // Next state and the values the registers take at the next edge.
   // SW skips the read entirely; SB/SH read first so the untouched lanes
   // can be written back unchanged.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wen_d     = wen_q;
      f3_d      = f3_q;
      wd_d      = wd_q;
      wdata_m_d = wdata_m_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.REQ) begin
               addr_d = bus.ADDR;
               wen_d  = bus.WEN;
               f3_d   = bus.FUNCT3;
               wd_d   = bus.WDATA;
               if (fault) begin
                  state_d = FAULT;
               end else if (bus.WEN && (bus.FUNCT3 == F3_W)) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (wen_q) begin
               wdata_m_d = mergedWord;
               state_d   = WRITE;
            end else begin
               rdata_d = loadVal;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         WRITE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         FAULT: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight access before it can write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wen_q     <= 1'b0;
         f3_q      <= 3'b000;
         wd_q      <= '0;
         wdata_m_q <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         f3_q      <= f3_d;
         wd_q      <= wd_d;
         wdata_m_q <= wdata_m_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Memory-side and status outputs. MEM_A comes straight from the latched
   // address so it stays constant from READ through WRITE.
   always_comb begin
      bus.MEM_A  = {2'b00, addr_q[A_WIDTH-1:2]};
      bus.MEM_WE = (state_q == WRITE);
      bus.MEM_WD = (f3_q == F3_W) ? wd_q : wdata_m_q;
      bus.BUSY   = (state_q != IDLE);
      bus.RDATA  = rdata_q;
      bus.DONE   = done_q;
      bus.ERR    = err_q;
   end

endmodule
